// File: rtl/l2_responder.sv
// Behavioural L2 endpoint: answers bus-controller read/write requests
// with a block-wide read value and a state after a programmable latency.
package l2_pkg;
    typedef enum logic [1:0] {
        L2_FREE   = 2'd0,
        L2_BUSY   = 2'd1,
        L2_ACCESS = 2'd2,
        L2_ERROR  = 2'd3
    } l2_state_t;
endpackage

module l2_responder
    import l2_pkg::*;
#(
    parameter int          BLOCK_SIZE  = 2,
    parameter int          LATENCY     = 4,
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic                    l2REN,
    input  logic                    l2WEN,
    input  logic [31:0]             l2addr,
    input  logic [31:0]             l2store,
    output logic [32*BLOCK_SIZE-1:0] l2load,
    output logic [1:0]              l2state
);
    localparam int DATA_WIDTH = 32 * BLOCK_SIZE;
    localparam int AW         = $clog2(DEPTH_WORDS);

    l2_state_t             state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  wr_q, wr_d;
    logic [AW-1:0]         woff_q, woff_d;
    logic [31:0]           store_q, store_d;
    logic [DATA_WIDTH-1:0] load_q;
    logic [31:0]           mem_q [DEPTH_WORDS];

    logic [31:0]           diff;
    logic [AW-1:0]         woff_in;
    logic                  bad_addr;

    logic                  acc_en;
    logic                  acc_wr;
    logic [AW-1:0]         acc_woff;
    logic [31:0]           acc_data;
    logic [AW-1:0]         rd_base;
    logic [DATA_WIDTH-1:0] rd_blk;

    assign diff     = l2addr - BASE_ADDR;
    assign woff_in  = diff[AW+1:2];
    assign bad_addr = (l2addr < BASE_ADDR)
                   || (l2addr[1:0] != 2'b00)
                   || ({2'b00, diff[31:2]} >= 32'(DEPTH_WORDS));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_d     = wr_q;
        woff_d   = woff_q;
        store_d  = store_q;
        acc_en   = 1'b0;
        acc_wr   = wr_q;
        acc_woff = woff_q;
        acc_data = store_q;
        case (state_q)
            L2_FREE: begin
                if (l2REN && l2WEN) begin
                    state_d = L2_ERROR;
                end else if (l2REN || l2WEN) begin
                    if (bad_addr) begin
                        state_d = L2_ERROR;
                    end else begin
                        wr_d    = l2WEN;
                        woff_d  = woff_in;
                        store_d = l2store;
                        cnt_d   = 8'(LATENCY - 1);
                        // Single-cycle latency accesses on the sampling edge
                        if (LATENCY == 1) begin
                            state_d  = L2_ACCESS;
                            acc_en   = 1'b1;
                            acc_wr   = l2WEN;
                            acc_woff = woff_in;
                            acc_data = l2store;
                        end else begin
                            state_d = L2_BUSY;
                        end
                    end
                end
            end
            L2_BUSY: begin
                if (!l2REN && !l2WEN) begin
                    state_d = L2_FREE;
                end else if (cnt_q == 8'd1) begin
                    state_d = L2_ACCESS;
                    acc_en  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = L2_FREE;
        endcase
    end

    assign rd_base = acc_woff - (acc_woff % AW'(BLOCK_SIZE));

    always_comb begin
        rd_blk = '0;
        for (int i = 0; i < BLOCK_SIZE; i++) begin
            rd_blk[32*i +: 32] = mem_q[rd_base + AW'(i)];
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= L2_FREE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            woff_q  <= '0;
            store_q <= '0;
            load_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            woff_q  <= woff_d;
            store_q <= store_d;
            if (acc_en && !acc_wr) begin
                load_q <= rd_blk;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (acc_en && acc_wr) begin
            mem_q[acc_woff] <= acc_data;
        end
    end

    assign l2state = state_q;
    assign l2load  = load_q;

endmodule
